// File: rtl/alu_pkg.sv
// Purpose: shared types and constants for the ALU issue stage.
//   alu_f_t   : 3-bit ALU function codes presented to EX
//   OP_*/FN_* : supported MIPS opcode / R-type funct values
//   decoded_t : the {A, B, F, illegal} bundle carried through the stage
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned F_W    = 3;

    typedef enum logic [F_W-1:0] {
        F_AND  = 3'b000,
        F_OR   = 3'b001,
        F_ADD  = 3'b010,
        F_RSVD = 3'b011,
        F_ANDN = 3'b100,
        F_ORN  = 3'b101,
        F_SUB  = 3'b110,
        F_SLT  = 3'b111
    } alu_f_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FN_W-1:0] FN_AND  = 6'h24;
    localparam logic [FN_W-1:0] FN_OR   = 6'h25;
    localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_f_t            f;
        logic              illegal;
    } decoded_t;

    localparam decoded_t DECODED_RST = '{a: '0, b: '0, f: F_ADD, illegal: 1'b0};

endpackage

// File: rtl/alu_op_decoder.sv
// Purpose: combinational opcode/funct/imm decode into the ALU bundle.
// Ports:
//   opcode_i, funct_i : instruction fields [31:26], [5:0]
//   rs_val_i, rt_val_i: forwarded register operands
//   imm_i             : instruction [15:0]
//   dec_o             : decoded {A, B, F, illegal}; unsupported ops give A=B=0, F=ADD
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [FN_W-1:0]   funct_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic [DATA_W-1:0] rt_val_i,
    input  logic [IMM_W-1:0]  imm_i,
    output decoded_t          dec_o
);

    logic [DATA_W-1:0] sext_c;
    logic [DATA_W-1:0] zext_c;
    logic [DATA_W-1:0] b_c;
    alu_f_t            f_c;
    logic              legal_c;

    assign sext_c = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign zext_c = DATA_W'(imm_i);

    // Function code and operand-B source selection
    always_comb begin
        legal_c = 1'b1;
        f_c     = F_ADD;
        b_c     = rt_val_i;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_ADDU: f_c = F_ADD;
                    FN_SUB, FN_SUBU: f_c = F_SUB;
                    FN_AND:          f_c = F_AND;
                    FN_OR:           f_c = F_OR;
                    FN_SLT:          f_c = F_SLT;
                    default:         legal_c = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                f_c = F_ADD;
                b_c = sext_c;
            end
            OP_SLTI: begin
                f_c = F_SLT;
                b_c = sext_c;
            end
            OP_ANDI: begin
                f_c = F_AND;
                b_c = zext_c;
            end
            OP_ORI: begin
                f_c = F_OR;
                b_c = zext_c;
            end
            OP_BEQ, OP_BNE: f_c = F_SUB;
            default:        legal_c = 1'b0;
        endcase
    end

    // Illegal ops still flow to EX, but with neutral operands
    always_comb begin
        dec_o.a       = legal_c ? rs_val_i : '0;
        dec_o.b       = legal_c ? b_c : '0;
        dec_o.f       = legal_c ? f_c : F_ADD;
        dec_o.illegal = ~legal_c;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose: ID->EX issue stage. Decodes the instruction and hands {A, B, F, illegal}
//   to EX over valid/ready, with a 2-entry (main + skid) buffer so that in_ready
//   is a pure register and back-pressure never drops or duplicates an op.
// Ports:
//   CLK, RST               : clock, asynchronous active-low reset
//   in_valid, in_ready     : ID-side handshake (in_ready registered)
//   opcode, funct, imm     : instruction fields
//   rs_val, rt_val         : forwarded operands
//   flush                  : discard all held ops and any same-cycle input
//   out_valid, out_ready   : EX-side handshake
//   A, B, F, illegal       : registered bundle toward EX
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [FN_W-1:0]  funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [IMM_W-1:0] imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [F_W-1:0]   F,
    output logic             illegal
);

    decoded_t dec_c;
    decoded_t main_q, main_d;
    decoded_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     in_ready_q;
    logic     accept_c;

    alu_op_decoder u_dec (
        .opcode_i (opcode),
        .funct_i  (funct),
        .rs_val_i (DATA_W'(rs_val)),
        .rt_val_i (DATA_W'(rt_val)),
        .imm_i    (imm),
        .dec_o    (dec_c)
    );

    assign accept_c = in_valid & in_ready_q & ~flush;

    // Buffer control: skid always refills main first, preserving FIFO order
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // in_ready is low whenever skid is full, so no accept competes here
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                main_d      = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
    end

    // State registers; in_ready tracks the next skid state so it is never combinational
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            main_q       <= DECODED_RST;
            skid_q       <= DECODED_RST;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign A         = WIDTH'(main_q.a);
    assign B         = WIDTH'(main_q.b);
    assign F         = main_q.f;
    assign illegal   = main_q.illegal;

endmodule
